// File: rtl/fir_pkg.sv
// Shared FIR datapath definitions: default sample width, default tap count
// and the signed sample type.
package fir_pkg;

   localparam int SAMPLE_W = 16;
   localparam int TAPS     = 8;

   typedef logic signed [SAMPLE_W-1:0] sample_t;

endpackage : fir_pkg

// File: rtl/fir_tap_reg.sv
// One delay-line stage: N-bit sample plus its valid flag, loaded on shift,
// cleared by reset or flush.
module fir_tap_reg
   import fir_pkg::*;
#(
   parameter int N = SAMPLE_W
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         clr,
   input  logic         shift,
   input  logic [N-1:0] d,
   input  logic         vin,
   output logic [N-1:0] q,
   output logic         v
);

   always_ff @(posedge clk) begin
      if (rst || clr) begin
         q <= '0;
         v <= 1'b0;
      end else if (shift) begin
         q <= d;
         v <= vin;
      end
   end

endmodule : fir_tap_reg

// File: rtl/fir_delay_line.sv
// Parametrised FIR tap delay line: DEPTH stages shifted on each accepted
// sample, with fill counter, primed flag and the sample leaving the window.
module fir_delay_line
   import fir_pkg::*;
#(
   parameter int N     = SAMPLE_W,
   parameter int DEPTH = TAPS,
   parameter int CW    = $clog2(DEPTH + 1)
) (
   input  logic             CLK,
   input  logic             rst,
   input  logic             in_valid,
   input  logic [N-1:0]     in_data,
   input  logic             hold,
   input  logic             flush,
   output logic             in_ready,
   output logic [DEPTH*N-1:0] taps,
   output logic [DEPTH-1:0] tap_valid,
   output logic [CW-1:0]    count,
   output logic             primed,
   output logic             out_valid,
   output logic [N-1:0]     out_data
);

   logic           accept;
   logic [N-1:0]   q [DEPTH];
   logic [DEPTH-1:0] v;

   assign in_ready = !hold;
   assign accept   = in_valid && !hold && !flush;

   for (genvar k = 0; k < DEPTH; k++) begin : g_tap
      logic [N-1:0] d;
      logic         vin;

      if (k == 0) begin : g_head
         assign d   = in_data;
         assign vin = 1'b1;
      end else begin : g_body
         assign d   = q[k-1];
         assign vin = v[k-1];
      end

      fir_tap_reg #(.N(N)) u_tap (
         .clk   (CLK),
         .rst   (rst),
         .clr   (flush),
         .shift (accept),
         .d     (d),
         .vin   (vin),
         .q     (q[k]),
         .v     (v[k])
      );

      assign taps[k*N +: N] = q[k];
   end

   assign tap_valid = v;

   // primed is set on the accept that brings count to DEPTH; out_data captures
   // the old last tap, which the same edge overwrites in the chain.
   always_ff @(posedge CLK) begin
      if (rst || flush) begin
         count     <= '0;
         primed    <= 1'b0;
         out_valid <= 1'b0;
         out_data  <= '0;
      end else begin
         out_valid <= accept && primed;
         if (accept) begin
            if (count != CW'(DEPTH))
               count <= count + CW'(1);
            if (count >= CW'(DEPTH - 1))
               primed <= 1'b1;
            if (primed)
               out_data <= q[DEPTH-1];
         end
      end
   end

endmodule : fir_delay_line

// File: tb/tb_fir_delay_line.sv
// Directed self-checking bench for fir_delay_line: default 16x8 instance and
// a 24-bit, 2-deep instance for the width/depth sweep.
module tb_fir_delay_line;

   logic         clk = 1'b0;
   logic         rst;
   logic         in_valid, hold, flush;
   logic [15:0]  in_data;
   logic         in_ready;
   logic [127:0] taps;
   logic [7:0]   tap_valid;
   logic [3:0]   count;
   logic         primed, out_valid;
   logic [15:0]  out_data;

   logic         in_valid2;
   logic [23:0]  in_data2;
   logic         in_ready2;
   logic [47:0]  taps2;
   logic [1:0]   tap_valid2;
   logic [1:0]   count2;
   logic         primed2, out_valid2;
   logic [23:0]  out_data2;

   int tests  = 0;
   int failed = 0;

   always #5 clk = ~clk;

   fir_delay_line u_dut (
      .CLK       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .hold      (hold),
      .flush     (flush),
      .in_ready  (in_ready),
      .taps      (taps),
      .tap_valid (tap_valid),
      .count     (count),
      .primed    (primed),
      .out_valid (out_valid),
      .out_data  (out_data)
   );

   fir_delay_line #(.N(24), .DEPTH(2)) u_dut2 (
      .CLK       (clk),
      .rst       (rst),
      .in_valid  (in_valid2),
      .in_data   (in_data2),
      .hold      (1'b0),
      .flush     (1'b0),
      .in_ready  (in_ready2),
      .taps      (taps2),
      .tap_valid (tap_valid2),
      .count     (count2),
      .primed    (primed2),
      .out_valid (out_valid2),
      .out_data  (out_data2)
   );

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      tests++;
      assert (obs === exp) else begin
         failed++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b1; in_valid = 1'b1; in_data = 16'h7FFF; hold = 1'b0; flush = 1'b0;
      in_valid2 = 1'b0; in_data2 = '0;
      tick();
      tick();
      check("rst_taps",      taps,      128'h0);
      check("rst_tap_valid", tap_valid, 8'h00);
      check("rst_count",     count,     4'd0);
      check("rst_primed",    primed,    1'b0);
      check("rst_out_valid", out_valid, 1'b0);
      check("rst_out_data",  out_data,  16'h0);
      check("rst_in_ready",  in_ready,  1'b1);

      // fill 1..8
      rst = 1'b0;
      for (int i = 1; i <= 8; i++) begin
         in_data = 16'(i);
         tick();
         check("fill_count", count, 128'(i));
         check("fill_out_valid", out_valid, 1'b0);
         if (i == 7) check("fill7_primed", primed, 1'b0);
      end
      check("fill_taps", taps, {16'd1, 16'd2, 16'd3, 16'd4, 16'd5, 16'd6, 16'd7, 16'd8});
      check("fill_tap_valid", tap_valid, 8'hFF);
      check("fill_primed", primed, 1'b1);

      // steady stream
      in_data = 16'd9;
      tick();
      check("s9_out_valid", out_valid, 1'b1);
      check("s9_out_data",  out_data,  16'd1);
      check("s9_count",     count,     4'd8);
      in_data = 16'd10;
      tick();
      check("s10_out_valid", out_valid, 1'b1);
      check("s10_out_data",  out_data,  16'd2);
      check("s10_count",     count,     4'd8);
      check("s10_taps", taps, {16'd3, 16'd4, 16'd5, 16'd6, 16'd7, 16'd8, 16'd9, 16'd10});

      // hold with a pending sample
      hold = 1'b1; in_data = 16'h00AA;
      #1;
      check("hold_in_ready", in_ready, 1'b0);
      for (int i = 0; i < 3; i++) begin
         tick();
         check("hold_taps", taps, {16'd3, 16'd4, 16'd5, 16'd6, 16'd7, 16'd8, 16'd9, 16'd10});
         check("hold_out_valid", out_valid, 1'b0);
         check("hold_out_data",  out_data,  16'd2);
         check("hold_count",     count,     4'd8);
      end
      hold = 1'b0; in_valid = 1'b0;
      tick();
      check("idle_out_valid", out_valid, 1'b0);
      check("idle_primed",    primed,    1'b1);

      // flush colliding with a valid sample
      flush = 1'b1; in_valid = 1'b1; in_data = 16'h1234;
      tick();
      check("flush_taps",      taps,      128'h0);
      check("flush_tap_valid", tap_valid, 8'h00);
      check("flush_count",     count,     4'd0);
      check("flush_primed",    primed,    1'b0);
      check("flush_out_data",  out_data,  16'h0);
      flush = 1'b0; in_data = 16'd5;
      tick();
      check("post_flush_taps",      taps,      128'h5);
      check("post_flush_count",     count,     4'd1);
      check("post_flush_tap_valid", tap_valid, 8'h01);
      in_valid = 1'b0;

      // 24-bit, 2-deep sweep with signed values
      in_valid2 = 1'b1; in_data2 = 24'hFFFFFF;
      tick();
      in_data2 = 24'hFF8000;
      tick();
      check("w_taps2",       taps2,      {24'hFFFFFF, 24'hFF8000});
      check("w_primed2",     primed2,    1'b1);
      check("w_count2",      count2,     2'd2);
      check("w_out_valid2a", out_valid2, 1'b0);
      in_data2 = 24'h000003;
      tick();
      check("w_out_valid2b", out_valid2, 1'b1);
      check("w_out_data2",   out_data2,  24'hFFFFFF);
      check("w_taps2b",      taps2,      {24'hFF8000, 24'h000003});
      check("w_count2b",     count2,     2'd2);
      check("w_in_ready2",   in_ready2,  1'b1);
      check("w_tap_valid2",  tap_valid2, 2'b11);
      in_valid2 = 1'b0;
      tick();

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule : tb_fir_delay_line
